// File: rtl/ab_link_arbiter_if.sv
// Handshake bundle between the A/B requesters, the shared link and the arbiter.
// Modports: master drives requests and link_ready; slave is the arbiter side.
interface ab_link_arbiter_if #(
   parameter int A_TO_B_BITWIDTH = 8,
   parameter int B_TO_A_BITWIDTH = 8,
   parameter int LINK_BITWIDTH   = 8
);
   logic                       a_req_valid;
   logic [A_TO_B_BITWIDTH-1:0] a_req_data;
   logic                       a_req_ready;
   logic                       b_req_valid;
   logic [B_TO_A_BITWIDTH-1:0] b_req_data;
   logic                       b_req_ready;
   logic                       link_valid;
   logic                       link_dir;
   logic [LINK_BITWIDTH-1:0]   link_data;
   logic                       link_ready;
   logic [15:0]                a_beat_cnt;
   logic [15:0]                b_beat_cnt;

   modport master (
      output a_req_valid, a_req_data,
      output b_req_valid, b_req_data,
      output link_ready,
      input  a_req_ready, b_req_ready,
      input  link_valid, link_dir, link_data,
      input  a_beat_cnt, b_beat_cnt
   );

   modport slave (
      input  a_req_valid, a_req_data,
      input  b_req_valid, b_req_data,
      input  link_ready,
      output a_req_ready, b_req_ready,
      output link_valid, link_dir, link_data,
      output a_beat_cnt, b_beat_cnt
   );
endinterface

// File: rtl/ab_link_arbiter.sv
// Bidirectional A/B link arbiter: one shared link register, burst-limited grants.
// Ports: clk, rst (sync, active-high), bus (slave modport of ab_link_arbiter_if).
module ab_link_arbiter #(
   parameter int A_TO_B_BITWIDTH = 8,
   parameter int B_TO_A_BITWIDTH = 8,
   parameter int LINK_BITWIDTH   = 8,
   parameter int MAX_BURST       = 4
) (
   input  logic                clk,
   input  logic                rst,
   ab_link_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT_A,
      GRANT_B
   } state_t;

   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

   state_t                   state_q, state_d;
   logic [3:0]               burst_q, burst_d;
   logic                     last_dir_q, last_dir_d;
   logic                     link_valid_q, link_valid_d;
   logic                     link_dir_q, link_dir_d;
   logic [LINK_BITWIDTH-1:0] link_data_q, link_data_d;
   logic [15:0]              a_cnt_q, a_cnt_d;
   logic [15:0]              b_cnt_q, b_cnt_d;

   logic slot_free;
   logic a_rdy;
   logic b_rdy;
   logic acc_a;
   logic acc_b;
   logic burst_end;

   // The link slot can take a beat if empty or being drained this cycle.
   assign slot_free = !link_valid_q || bus.link_ready;
   assign a_rdy     = !rst && (state_q == GRANT_A) && slot_free;
   assign b_rdy     = !rst && (state_q == GRANT_B) && slot_free;
   assign acc_a     = a_rdy && bus.a_req_valid;
   assign acc_b     = b_rdy && bus.b_req_valid;
   assign burst_end = (burst_q == BURST_LAST);

   always_comb begin
      state_d      = state_q;
      burst_d      = burst_q;
      last_dir_d   = last_dir_q;
      link_valid_d = link_valid_q;
      link_dir_d   = link_dir_q;
      link_data_d  = link_data_q;
      a_cnt_d      = a_cnt_q;
      b_cnt_d      = b_cnt_q;

      unique case (state_q)
         IDLE: begin
            // last_dir_q=1 means B went last, so a tie goes to A.
            if (bus.a_req_valid && (!bus.b_req_valid || last_dir_q)) begin
               state_d    = GRANT_A;
               burst_d    = '0;
               last_dir_d = 1'b0;
            end else if (bus.b_req_valid) begin
               state_d    = GRANT_B;
               burst_d    = '0;
               last_dir_d = 1'b1;
            end
         end
         GRANT_A: begin
            if (!bus.a_req_valid) begin
               if (bus.b_req_valid) begin
                  state_d    = GRANT_B;
                  burst_d    = '0;
                  last_dir_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (acc_a) begin
               if (burst_end && bus.b_req_valid) begin
                  state_d    = GRANT_B;
                  burst_d    = '0;
                  last_dir_d = 1'b1;
               end else if (!burst_end) begin
                  // Saturates at the limit while B stays idle.
                  burst_d = burst_q + 4'd1;
               end
            end
         end
         GRANT_B: begin
            if (!bus.b_req_valid) begin
               if (bus.a_req_valid) begin
                  state_d    = GRANT_A;
                  burst_d    = '0;
                  last_dir_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else if (acc_b) begin
               if (burst_end && bus.a_req_valid) begin
                  state_d    = GRANT_A;
                  burst_d    = '0;
                  last_dir_d = 1'b0;
               end else if (!burst_end) begin
                  burst_d = burst_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (acc_a) begin
         link_valid_d = 1'b1;
         link_dir_d   = 1'b0;
         link_data_d  = LINK_BITWIDTH'(bus.a_req_data);
         a_cnt_d      = a_cnt_q + 16'd1;
      end else if (acc_b) begin
         link_valid_d = 1'b1;
         link_dir_d   = 1'b1;
         link_data_d  = LINK_BITWIDTH'(bus.b_req_data);
         b_cnt_d      = b_cnt_q + 16'd1;
      end else if (bus.link_ready) begin
         link_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         burst_q      <= '0;
         last_dir_q   <= 1'b1;
         link_valid_q <= 1'b0;
         link_dir_q   <= 1'b0;
         link_data_q  <= '0;
         a_cnt_q      <= '0;
         b_cnt_q      <= '0;
      end else begin
         state_q      <= state_d;
         burst_q      <= burst_d;
         last_dir_q   <= last_dir_d;
         link_valid_q <= link_valid_d;
         link_dir_q   <= link_dir_d;
         link_data_q  <= link_data_d;
         a_cnt_q      <= a_cnt_d;
         b_cnt_q      <= b_cnt_d;
      end
   end

   assign bus.a_req_ready = a_rdy;
   assign bus.b_req_ready = b_rdy;
   assign bus.link_valid  = link_valid_q;
   assign bus.link_dir    = link_dir_q;
   assign bus.link_data   = link_data_q;
   assign bus.a_beat_cnt  = a_cnt_q;
   assign bus.b_beat_cnt  = b_cnt_q;

endmodule

// File: doc/ab_link_arbiter.md
AB_LINK_ARBITER -- requirements
Module: ab_link_arbiter

Interface
REQ-001 Parameter A_TO_B_BITWIDTH, default 8, gives the width of A-side request data.
REQ-002 Parameter B_TO_A_BITWIDTH, default 8, gives the width of B-side request data.
REQ-003 Parameter LINK_BITWIDTH, default 8, gives the shared link data width and SHALL be >= both request widths.
REQ-004 Parameter MAX_BURST, default 4, range 1..15, gives the maximum consecutive beats one side may send while the other side is waiting.
REQ-005 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port a_req_valid, input, 1: A has a beat for B.
REQ-008 Port a_req_data, input, A_TO_B_BITWIDTH: the A beat payload.
REQ-009 Port a_req_ready, output, 1: A beat accepted this cycle when high together with a_req_valid.
REQ-010 Port b_req_valid, input, 1: B has a beat for A.
REQ-011 Port b_req_data, input, B_TO_A_BITWIDTH: the B beat payload.
REQ-012 Port b_req_ready, output, 1: B beat accepted this cycle when high together with b_req_valid.
REQ-013 Port link_valid, output, 1: the link register holds a beat.
REQ-014 Port link_dir, output, 1: direction of the held beat; 0 = A to B, 1 = B to A.
REQ-015 Port link_data, output, LINK_BITWIDTH: payload of the held beat, zero-extended.
REQ-016 Port link_ready, input, 1: the link consumer takes the held beat when high together with link_valid.
REQ-017 Port a_beat_cnt, output, 16: count of accepted A beats.
REQ-018 Port b_beat_cnt, output, 16: count of accepted B beats.

Function
REQ-019 FSM states SHALL be IDLE, GRANT_A and GRANT_B; a_req_ready SHALL be asserted only in GRANT_A and b_req_ready only in GRANT_B.
REQ-020 Link slot free = !link_valid || link_ready; in GRANT_X, X_req_ready SHALL equal the slot-free condition.
REQ-021 An accepted beat SHALL load link_data, link_dir and link_valid=1 on the next edge, giving 1-cycle latency from acceptance to appearance on the link.
REQ-022 link_valid SHALL clear on the edge after link_ready&&link_valid with no new acceptance; while link_valid=1 and link_ready=0, link_data/link_dir SHALL hold stable.
REQ-023 IDLE: both valid -> grant the side opposite last_dir; only one valid -> grant that side; neither valid -> stay IDLE.
REQ-024 On entry to a GRANT state, burst_cnt SHALL be set to 0 and last_dir SHALL be set to the granted side.
REQ-025 In GRANT_X, each acceptance SHALL increment burst_cnt.
REQ-026 In GRANT_X, if an acceptance occurs with burst_cnt==MAX_BURST-1 while the other side is valid, the FSM SHALL move to GRANT_other on the next edge.
REQ-027 In GRANT_X, if X_req_valid=0, the FSM SHALL move to GRANT_other if the other side is valid, else to IDLE, on the next edge.
REQ-028 In GRANT_X, with the other side idle, the burst limit SHALL NOT apply; X SHALL keep the grant and burst_cnt SHALL saturate at MAX_BURST-1.
REQ-029 A requester SHALL NOT be granted if its valid drops at the same edge as the grant decision; the IDLE decision SHALL use current-cycle valids only.
REQ-030 a_beat_cnt/b_beat_cnt SHALL increment by 1 per acceptance and wrap from 0xFFFF to 0x0000.

Reset
REQ-031 With rst=1 at an edge: state=IDLE, link_valid=0, link_dir=0, link_data=0, counters=0, burst_cnt=0, last_dir=1 (A wins the first tie).
REQ-032 During rst=1, a_req_ready and b_req_ready SHALL be 0.
REQ-033 Reset mid-transfer SHALL discard any held link beat with no flush.

Verification
REQ-034 After reset, a_req_valid=b_req_valid=1 held, link_ready=1 -> beats A,A,A,A,B,B,B,B,A..., with the first link_valid one cycle after the first acceptance and link_dir=0.
REQ-035 A only valid, 10 beats, link_ready=1 -> 10 consecutive acceptances with no switch; a_beat_cnt=10.
REQ-036 Link beat held, link_ready=0 for 5 cycles -> link_data stable, a_req_ready=0; link_ready=1 -> next beat loaded the following edge.
REQ-037 a_beat_cnt preloaded to 0xFFFF via 65535 beats, one more beat -> a_beat_cnt=0x0000.
REQ-038 rst asserted while link_valid=1 and in GRANT_B -> next cycle link_valid=0, state IDLE; after release, tied valids -> A granted first.
